updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 80 ++++++++
 tb/tb_updown_mod_counter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter over the range 0..limit with a programmable step,
// wrap or saturate on range exit, a one-cycle terminal-count pulse and a sticky overflow flag.
module updown_mod_counter #(
    parameter int n   = 32,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         up_down,
    input  logic         ld,
    input  logic [n-1:0] d,
    input  logic [n-1:0] step,
    input  logic [n-1:0] limit,
    output logic [n-1:0] r,
    output logic         tc,
    output logic         ovf,
    output logic         zero
);

    logic [n:0]   sum_ext;
    logic         up_over;
    logic         dn_under;
    logic [n-1:0] ld_val;
    logic [n-1:0] diff;

    logic [n-1:0] r_nxt;
    logic         tc_nxt;
    logic         ovf_nxt;

    // The sum keeps its carry bit so a count past 2^n-1 is still seen as leaving the range.
    assign sum_ext  = {1'b0, r} + {1'b0, step};
    assign up_over  = (sum_ext > {1'b0, limit});
    assign dn_under = (step > r);
    assign diff     = r - step;
    assign ld_val   = (d > limit) ? limit : d;

    always_comb begin
        r_nxt   = r;
        tc_nxt  = 1'b0;
        ovf_nxt = ovf;
        if (ld) begin
            r_nxt   = ld_val;
            ovf_nxt = 1'b0;
        end else if (en && (step != '0)) begin
            if (up_down) begin
                if (up_over) begin
                    r_nxt   = SAT ? limit : '0;
                    tc_nxt  = 1'b1;
                    ovf_nxt = 1'b1;
                end else begin
                    r_nxt = sum_ext[n-1:0];
                end
            end else begin
                if (dn_under) begin
                    r_nxt   = SAT ? '0 : limit;
                    tc_nxt  = 1'b1;
                    ovf_nxt = 1'b1;
                end else begin
                    r_nxt = diff;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            r   <= r_nxt;
            tc  <= tc_nxt;
            ovf <= ovf_nxt;
        end
    end

    assign zero = (r == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: directed vectors push hand-computed expectations, a monitor
// pops one entry per clock edge and compares it against the selected instance.
module tb_updown_mod_counter;

    logic       clk;
    logic       clr, en, up_down, ld;
    logic [7:0] d, step, limit;
    logic [7:0] r0, r1;
    logic       tc0, tc1, ovf0, ovf1, zero0, zero1;

    typedef struct {
        string      nm;
        bit         sel;
        logic [7:0] r;
        logic       tc;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    updown_mod_counter #(.n(8), .SAT(1'b0)) dut_wrap (
        .clk(clk), .clr(clr), .en(en), .up_down(up_down), .ld(ld),
        .d(d), .step(step), .limit(limit),
        .r(r0), .tc(tc0), .ovf(ovf0), .zero(zero0)
    );

    updown_mod_counter #(.n(8), .SAT(1'b1)) dut_sat (
        .clk(clk), .clr(clr), .en(en), .up_down(up_down), .ld(ld),
        .d(d), .step(step), .limit(limit),
        .r(r1), .tc(tc1), .ovf(ovf1), .zero(zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs settle after the edge that consumed the queued vector.
    always @(posedge clk) begin
        exp_t       e;
        logic [7:0] ar;
        logic       atc, aov, az, ez;
        #1;
        if (q.size() > 0) begin
            e   = q.pop_front();
            ar  = e.sel ? r1    : r0;
            atc = e.sel ? tc1   : tc0;
            aov = e.sel ? ovf1  : ovf0;
            az  = e.sel ? zero1 : zero0;
            ez  = (e.r == 8'd0);
            total++;
            if (ar === e.r && atc === e.tc && aov === e.ovf && az === ez)
                passed++;
            else
                $display("FAIL %s: got r=%0d tc=%b ovf=%b zero=%b, expected r=%0d tc=%b ovf=%b zero=%b",
                         e.nm, ar, atc, aov, az, e.r, e.tc, e.ovf, ez);
        end
    end

    task automatic vec(input string nm, input bit sel,
                       input bit c, input bit l, input bit e, input bit ud,
                       input int dd, input int st, input int lim,
                       input bit chk, input int er, input bit etc, input bit eov);
        exp_t x;
        @(negedge clk);
        clr     = c;
        ld      = l;
        en      = e;
        up_down = ud;
        d       = dd[7:0];
        step    = st[7:0];
        limit   = lim[7:0];
        if (chk) begin
            x.nm  = nm;
            x.sel = sel;
            x.r   = er[7:0];
            x.tc  = etc;
            x.ovf = eov;
            q.push_back(x);
        end
    endtask

    initial begin
        clr = 1'b0; en = 1'b0; up_down = 1'b0; ld = 1'b0;
        d = '0; step = '0; limit = '0;

        // wrap mode: 0..9 then wrap
        vec("clr_reset", 0, 1,0,0,0, 0,0,9, 1, 0,0,0);
        for (int i = 1; i <= 9; i++)
            vec("up_lim9", 0, 0,0,1,1, 0,1,9, 1, i,0,0);
        vec("wrap_to_0", 0, 0,0,1,1, 0,1,9, 1, 0,1,1);
        for (int i = 0; i < 5; i++)
            vec("hold_en0", 0, 0,0,0,1, 0,1,9, 1, 0,0,1);
        vec("resume_up", 0, 0,0,1,1, 0,1,9, 1, 1,0,1);

        // underflow wraps to limit, then up past 255 wraps to 0
        vec("ld_2", 0, 0,1,0,0, 2,5,255, 1, 2,0,0);
        vec("down_under", 0, 0,0,1,0, 0,5,255, 1, 255,1,1);
        vec("up_carry", 0, 0,0,1,1, 0,1,255, 1, 0,1,1);
        vec("step0_hold", 0, 0,0,1,0, 0,0,255, 1, 0,0,1);
        vec("ld_10", 0, 0,1,0,0, 10,0,255, 1, 10,0,0);
        vec("down_4", 0, 0,0,1,0, 0,4,255, 1, 6,0,0);
        vec("down_exact", 0, 0,0,1,0, 0,6,255, 1, 0,0,0);

        // load clamps to limit, lowered limit forces overflow
        vec("ld_clamp", 0, 0,1,0,0, 50,0,20, 1, 20,0,0);
        vec("lim_lowered", 0, 0,0,1,1, 0,1,10, 1, 0,1,1);
        vec("lim0_up", 0, 0,0,1,1, 0,3,0, 1, 0,1,1);
        vec("lim0_down", 0, 0,0,1,0, 0,1,0, 1, 0,1,1);

        // priority and clear behaviour
        vec("clr_over_ld", 0, 1,1,1,1, 77,5,255, 1, 0,0,0);
        vec("ld_over_en", 0, 0,1,1,1, 77,5,255, 1, 77,0,0);
        vec("under_77", 0, 0,0,1,0, 0,100,255, 1, 255,1,1);
        vec("ld_clears_ovf", 0, 0,1,1,0, 3,100,255, 1, 3,0,0);
        vec("up_to_4", 0, 0,0,1,1, 0,1,255, 1, 4,0,0);
        vec("clr_midcount", 0, 1,0,1,1, 0,1,255, 1, 0,0,0);
        vec("after_clr", 0, 0,0,1,1, 0,1,255, 1, 1,0,0);
        vec("ld_at_lim", 0, 0,1,0,1, 4,1,4, 1, 4,0,0);
        vec("clr_no_tc", 0, 1,0,1,1, 0,1,4, 1, 0,0,0);

        // saturate mode
        vec("sat_clr", 1, 1,0,0,0, 0,0,200, 1, 0,0,0);
        vec("sat_ld198", 1, 0,1,0,1, 198,3,200, 1, 198,0,0);
        vec("sat_up_200", 1, 0,0,1,1, 0,3,200, 1, 200,1,1);
        vec("sat_hold_200", 1, 0,0,1,1, 0,3,200, 1, 200,1,1);
        vec("sat_en0", 1, 0,0,0,1, 0,3,200, 1, 200,0,1);
        vec("sat_down50", 1, 0,0,1,0, 0,50,200, 1, 150,0,1);
        vec("sat_ld1", 1, 0,1,0,0, 1,2,200, 1, 1,0,0);
        vec("sat_under", 1, 0,0,1,0, 0,2,200, 1, 0,1,1);
        vec("sat_at_0", 1, 0,0,1,0, 0,2,200, 1, 0,1,1);
        vec("sat_step0", 1, 0,0,1,0, 0,0,200, 1, 0,0,1);
        vec("sat_ld100", 1, 0,1,0,1, 100,1,200, 1, 100,0,0);
        vec("sat_lim_low", 1, 0,0,1,1, 0,1,50, 1, 50,1,1);

        vec("idle", 0, 0,0,0,0, 0,0,0, 0, 0,0,0);
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        #2;
        total++;
        if (q.size() == 0)
            passed++;
        else
            $display("FAIL drain: %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
